// File: rtl/kvaz_mem_port.sv
// CPU-side memory port: latches one strobed byte access as {page, cpu_addr} and runs it
// over a req/ack handshake, holding cpu_ready low until ack or timeout.
module kvaz_mem_port #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_memrd,
    input  logic        cpu_memwr,
    input  logic [2:0]  bigram_addr,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Counter value seen in the last REQ cycle before the abort fires.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_memrd || cpu_memwr) begin
                    addr_d  = {bigram_addr, cpu_addr};
                    wdata_d = cpu_wdata;
                    we_d    = cpu_memwr;
                    req_d   = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = TIMEOUT_DATA;
                    end
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!cpu_memrd && !cpu_memwr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_ready   = ready_q;
    assign cpu_rd_data = rdata_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_kvaz_mem_port.sv
// Scoreboard bench for kvaz_mem_port: a driver plays CPU and memory controller and queues
// expected requests/completions; a negedge monitor pops and compares what the DUT presents.
module tb_kvaz_mem_port;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_memrd = 1'b0;
    logic        cpu_memwr = 1'b0;
    logic [2:0]  bigram_addr = '0;
    logic        cpu_ready;
    logic [7:0]  cpu_rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        err_timeout;

    kvaz_mem_port #(.TIMEOUT(TO), .TIMEOUT_DATA(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memrd(cpu_memrd), .cpu_memwr(cpu_memwr),
        .bigram_addr(bigram_addr),
        .cpu_ready(cpu_ready), .cpu_rd_data(cpu_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [7:0]  wd;
    } req_t;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         len;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural results only (last read value, sticky error).
    logic [7:0] m_rd  = 8'h00;
    logic       m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic       prev_req = 1'b0;
    logic       seen_reset = 1'b0;
    int         cur_len = 0;
    logic [7:0] exp_rd = 8'h00;
    logic       exp_err = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            seen_reset = 1'b1;
            prev_req   = 1'b0;
            cur_len    = 0;
            exp_rd     = 8'h00;
            exp_err    = 1'b0;
            done_q.delete();
        end else begin
            if (seen_reset) begin
                seen_reset = 1'b0;
                chk("rst_req",   {31'd0, mem_req},     32'd0);
                chk("rst_ready", {31'd0, cpu_ready},   32'd1);
                chk("rst_rd",    {24'd0, cpu_rd_data}, 32'd0);
                chk("rst_err",   {31'd0, err_timeout}, 32'd0);
                chk("rst_addr",  {13'd0, mem_addr},    32'd0);
                chk("rst_we",    {31'd0, mem_we},      32'd0);
                chk("rst_wdata", {24'd0, mem_wdata},   32'd0);
            end
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_we",    {31'd0, mem_we},    {31'd0, r.we});
                    chk("req_addr",  {13'd0, mem_addr},  {13'd0, r.addr});
                    chk("req_wdata", {24'd0, mem_wdata}, {24'd0, r.wd});
                end
                cur_len = 1;
            end else if (mem_req) begin
                cur_len++;
            end else if (prev_req) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_rd",  {24'd0, cpu_rd_data}, {24'd0, d.rd});
                    chk("done_err", {31'd0, err_timeout}, {31'd0, d.err});
                    chk("req_len",  cur_len, d.len);
                    exp_rd  = d.rd;
                    exp_err = d.err;
                end
            end else begin
                chk("idle_rd",  {24'd0, cpu_rd_data}, {24'd0, exp_rd});
                chk("idle_err", {31'd0, err_timeout}, {31'd0, exp_err});
            end
            chk("ready_vs_req", {31'd0, cpu_ready}, {31'd0, ~mem_req});
            prev_req = mem_req;
        end
    end

    // Issue strobe; returns once mem_req is seen (or the bound expires).
    task automatic start_access(input bit rd, input bit wr, input logic [2:0] pg,
                                input logic [15:0] a, input logic [7:0] wd, output bit ok);
        int w;
        req_t r;
        @(posedge clk) #1;
        cpu_memrd = rd; cpu_memwr = wr; bigram_addr = pg; cpu_addr = a; cpu_wdata = wd;
        r.we = wr; r.addr = {pg, a}; r.wd = wd;
        req_q.push_back(r);
        w = 0;
        do begin
            @(posedge clk) #1;
            w++;
        end while (!mem_req && w < 4);
        ok = mem_req;
        if (!ok) chk("req_seen", 32'd0, 32'd1);
        // Address-side inputs must no longer matter.
        bigram_addr = 3'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
    endtask

    // d in [0,TO-1]: ack in REQ cycle d; otherwise no ack (timeout).
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] pg, input logic [15:0] a,
                           input logic [7:0] wd, input int d, input logic [7:0] rdv,
                           input int hold, input bit spur);
        bit ok;
        done_t e;
        bit acked;
        acked = (d >= 0 && d < TO);
        if (acked) begin
            if (!wr) m_rd = rdv;
            e.len = d + 1;
        end else begin
            if (!wr) m_rd = 8'hFF;
            m_err = 1'b1;
            e.len = TO;
        end
        e.rd = m_rd; e.err = m_err;
        done_q.push_back(e);
        start_access(rd, wr, pg, a, wd, ok);
        if (ok) begin
            if (acked) begin
                repeat (d) begin
                    mem_rdata = 8'($urandom);
                    @(posedge clk) #1;
                end
                mem_ack = 1'b1; mem_rdata = rdv;
                @(posedge clk) #1;
                mem_ack = 1'b0; mem_rdata = 8'($urandom);
            end else begin
                repeat (TO) begin
                    mem_rdata = 8'($urandom);
                    @(posedge clk) #1;
                end
            end
        end
        for (int i = 0; i < hold; i++) begin
            if (spur && i == 0) begin mem_ack = 1'b1; mem_rdata = 8'h77; end
            @(posedge clk) #1;
            mem_ack = 1'b0;
        end
        cpu_memrd = 1'b0; cpu_memwr = 1'b0;
        @(posedge clk) #1;
        if (spur) begin
            mem_ack = 1'b1; mem_rdata = 8'h77;
            @(posedge clk) #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk) #1;
        reset = 1'b1;
        cpu_memrd = 1'b0; cpu_memwr = 1'b0; mem_ack = 1'b0;
        @(posedge clk) #1;
        reset = 1'b0;
        m_rd = 8'h00; m_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_txn(1, 0, 3'd2, 16'h1234, 8'h00, 3, 8'h5A, 2, 0);
        run_txn(0, 1, 3'd4, 16'hFFFF, 8'hA5, 1, 8'h00, 19, 0);
        run_txn(1, 1, 3'd0, 16'h0010, 8'h33, 2, 8'hC3, 1, 0);
        run_txn(1, 0, 3'd1, 16'h0200, 8'h00, -1, 8'h00, 1, 0);
        run_txn(0, 1, 3'd3, 16'h8000, 8'h44, 0, 8'h00, 0, 0);
        run_txn(1, 0, 3'd7, 16'hABCD, 8'h00, 4, 8'h99, 1, 0);

        // Reset two cycles into REQ, then a late ack
        start_access(1, 0, 3'd1, 16'h4321, 8'h00, ok);
        repeat (2) @(posedge clk) #1;
        pulse_reset();
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(posedge clk) #1;
        mem_ack = 1'b0;
        @(posedge clk) #1;

        run_txn(1, 0, 3'd5, 16'h0001, 8'h00, TO - 1, 8'h3C, 1, 0);
        run_txn(1, 0, 3'd6, 16'h0F0F, 8'h00, 0, 8'h11, 2, 1);
        run_txn(0, 1, 3'd2, 16'h2222, 8'h66, 1, 8'h00, 3, 1);
        run_txn(0, 1, 3'd0, 16'h0000, 8'h12, -1, 8'h00, 0, 0);
        pulse_reset();

        for (int t = 0; t < 200; t++) begin
            int k, d;
            k = $urandom_range(0, 2);
            d = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, TO - 1);
            run_txn(k != 1, k != 0, 3'($urandom), 16'($urandom), 8'($urandom), d,
                    8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_empty",  req_q.size(),  32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kvaz_mem_port.md
Name: kvaz_mem_port

Overview:
- Memory-side counterpart of the RAM-disk page mapper.
- Takes a CPU memory strobe plus the 3-bit page select from the mapper, and forms a 19-bit physical address {page, cpu_addr}.
- Runs one byte transaction over a req/ack handshake to the SDRAM/SRAM controller, stalling the CPU via cpu_ready until the transaction completes.
- Sits between the CPU bus/mapper and the memory controller's CPU port.

Parameters:
- TIMEOUT, 255: maximum clk cycles spent in REQ waiting for mem_ack before abort (1..255).
- TIMEOUT_DATA, 8'hFF: value returned on cpu_rd_data for an aborted read.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_memrd  in  1  CPU memory read strobe (level).
- cpu_memwr  in  1  CPU memory write strobe (level).
- bigram_addr  in  3  page from mapper; 0 = main RAM, 1..4 = RAM-disk pages.
- cpu_ready  out  1  high = no transaction pending; low = CPU must wait.
- cpu_rd_data  out  8  data from the last completed read.
- mem_req  out  1  request to memory controller.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  19  {page, cpu_addr}; valid while mem_req.
- mem_wdata  out  8  write data; valid while mem_req.
- mem_ack  in  1  one-cycle completion pulse from controller.
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- err_timeout  out  1  sticky: a request was aborted by timeout.

Behaviour:
- Decided: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state IDLE; cpu_ready 1; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0.
  - cpu_rd_data 8'h00; err_timeout 0; timeout counter 0.
- All outputs are registered.
- IDLE:
  - When cpu_memrd | cpu_memwr is sampled high, latch mem_addr = {bigram_addr, cpu_addr}, mem_wdata = cpu_wdata, and mem_we = cpu_memwr.
  - If both strobes are high, the access is a write.
  - Next cycle: mem_req = 1, cpu_ready = 0, state REQ, counter cleared.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. The counter increments each cycle.
  - On mem_ack:
    - For a read, cpu_rd_data <= mem_rdata.
    - Next cycle: mem_req = 0, cpu_ready = 1, state HOLD.
  - Timeout: if the counter reaches TIMEOUT with no ack:
    - mem_req = 0, cpu_ready = 1, err_timeout = 1, state HOLD.
    - For a read, cpu_rd_data = TIMEOUT_DATA. For a write, memory is not updated.
  - If ack and timeout occur in the same cycle, the ack is honoured and err_timeout is unchanged.
- HOLD:
  - Stay until cpu_memrd = 0 and cpu_memwr = 0 are sampled, then go to IDLE.
  - A strobe held for any length therefore produces exactly one transaction.
  - The earliest new acceptance is the cycle after the return to IDLE.
- Latency:
  - Strobe sampled at edge N gives mem_req high after N+1.
  - Ack sampled at edge M gives mem_req low, cpu_ready high and cpu_rd_data valid after M+1.
- mem_ack outside REQ is ignored and changes no state.
- Strobe or bigram_addr changes during REQ/HOLD are ignored, because the address is latched at acceptance.
- cpu_rd_data is not altered by writes or timeouts on writes.
- Reset in any state returns all state and outputs to reset values at the next edge. A pending request is dropped (mem_req falls) and the controller must tolerate this. err_timeout clears only on reset.
- Page arithmetic: no translation. Page 0 maps to 0x00000–0x0FFFF, page 4 to 0x40000–0x4FFFF. Pages 5–7 pass through unchanged.

Test Plan:
- Read page 2, cpu_addr 0x1234; controller acks 3 cycles after mem_req with mem_rdata 0x5A -> mem_addr 0x21234, mem_we 0, mem_req high exactly 4 cycles, cpu_rd_data 0x5A and cpu_ready 1 one cycle after ack.
- Write page 4, cpu_addr 0xFFFF, data 0xA5; cpu_memwr held 20 cycles; ack after 1 cycle -> mem_addr 0x4FFFF, mem_we 1, mem_wdata 0xA5, exactly one mem_req pulse; a second request occurs only after the strobe drops and rises again.
- Both strobes high, page 0, cpu_addr 0x0010, cpu_wdata 0x33 -> write issued (mem_we 1, mem_addr 0x00010), cpu_rd_data unchanged.
- TIMEOUT=8, read with no ack -> mem_req drops after 8 REQ cycles, cpu_rd_data 0xFF, err_timeout 1 and stays 1 through later good transactions; repeat with ack arriving on the 8th cycle -> data captured, err_timeout 0.
- Reset asserted 2 cycles into REQ -> next edge mem_req 0, cpu_ready 1, cpu_rd_data 0x00, err_timeout 0; a late mem_ack is ignored and a following read completes normally.
- Spurious mem_ack in IDLE and in HOLD with mem_rdata 0x77 -> cpu_rd_data and state unchanged.
